// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
//   Gshare direction predictor with a direct-mapped BTB and a speculative
//   global history register. It sits beside fetch, returns a registered
//   prediction one cycle after a lookup, and is trained from execute. After
//   reset an init sequencer walks both tables to clear them before `ready`
//   rises.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   ready           1 once table init is complete
//   lookup_valid/pc fetch lookup request
//   pred_valid      lookup_valid delayed one cycle
//   prediction      1 = predict taken
//   btb_hit         BTB valid and tag match for the looked-up pc
//   predicted_pc    BTB target when predicted taken and hit, else pc+4
//   pred_ghr        GHR used to index this lookup; returned with the update
//   update_*        resolved branch from execute (pc, direction, target, ghr)
//   mispred         repair the GHR from update_ghr/update_taken
// ---------------------------------------------------------------------------
module branch_predictor_gshare #(
    parameter int ADDRESS_BITS = 32,
    parameter int CTR_BITS     = 2,
    parameter int PHT_DEPTH    = 64,
    parameter int GHR_BITS     = 6,
    parameter int BTB_DEPTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    ready,
    input  logic                    lookup_valid,
    input  logic [ADDRESS_BITS-1:0] pc,
    output logic                    pred_valid,
    output logic                    prediction,
    output logic                    btb_hit,
    output logic [ADDRESS_BITS-1:0] predicted_pc,
    output logic [GHR_BITS-1:0]     pred_ghr,
    input  logic                    update_valid,
    input  logic [ADDRESS_BITS-1:0] update_pc,
    input  logic                    update_taken,
    input  logic [ADDRESS_BITS-1:0] update_target,
    input  logic [GHR_BITS-1:0]     update_ghr,
    input  logic                    mispred
);

    localparam int PIDX_W     = $clog2(PHT_DEPTH);
    localparam int BIDX_W     = $clog2(BTB_DEPTH);
    localparam int TAG_W      = ADDRESS_BITS - BIDX_W - 2;
    localparam int INIT_DEPTH = (PHT_DEPTH > BTB_DEPTH) ? PHT_DEPTH : BTB_DEPTH;
    localparam int INIT_W     = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Saturating up/down step of a PHT counter.
    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr,
                                                     input logic              up);
        if (up) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        end
        return (ctr == CTR_MIN) ? ctr : ctr - CTR_BITS'(1);
    endfunction

    // Tables: cleared by the init sequencer, so they carry no reset.
    logic [CTR_BITS-1:0]     pht_q       [PHT_DEPTH];
    logic                    btb_valid_q [BTB_DEPTH];
    logic [TAG_W-1:0]        btb_tag_q   [BTB_DEPTH];
    logic [ADDRESS_BITS-1:0] btb_tgt_q   [BTB_DEPTH];

    logic [0:0]              state_q, state_d;
    logic [INIT_W-1:0]       init_idx_q, init_idx_d;
    logic [GHR_BITS-1:0]     ghr_q, ghr_d;
    logic                    pred_valid_q, pred_valid_d;
    logic                    prediction_q, prediction_d;
    logic                    btb_hit_q, btb_hit_d;
    logic [ADDRESS_BITS-1:0] predicted_pc_q, predicted_pc_d;
    logic [GHR_BITS-1:0]     pred_ghr_q, pred_ghr_d;

    // Word-aligned PCs: the two low bits never index anything.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc[1:0], update_pc[1:0]};

    logic                    run;
    assign run = (state_q == ST_RUN);

    // Lookup side reads the tables as they stand this cycle, so a same-cycle
    // update to the same entry is only visible to the following lookup.
    logic [PIDX_W-1:0]       lk_pidx;
    logic [BIDX_W-1:0]       lk_bidx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    lk_pred;
    logic                    lk_hit;
    logic [ADDRESS_BITS-1:0] lk_next_pc;

    assign lk_pidx    = pc[PIDX_W+1:2] ^ PIDX_W'(ghr_q);
    assign lk_bidx    = pc[BIDX_W+1:2];
    assign lk_tag     = pc[ADDRESS_BITS-1:BIDX_W+2];
    assign lk_pred    = pht_q[lk_pidx][CTR_BITS-1];
    assign lk_hit     = btb_valid_q[lk_bidx] && (btb_tag_q[lk_bidx] == lk_tag);
    assign lk_next_pc = (lk_pred && lk_hit) ? btb_tgt_q[lk_bidx] : pc + ADDRESS_BITS'(4);

    // Update side indexes with the history the branch was predicted under.
    logic [PIDX_W-1:0]       up_pidx;
    logic [BIDX_W-1:0]       up_bidx;
    logic [TAG_W-1:0]        up_tag;

    assign up_pidx = update_pc[PIDX_W+1:2] ^ PIDX_W'(update_ghr);
    assign up_bidx = update_pc[BIDX_W+1:2];
    assign up_tag  = update_pc[ADDRESS_BITS-1:BIDX_W+2];

    always_comb begin
        state_d        = state_q;
        init_idx_d     = init_idx_q;
        ghr_d          = ghr_q;
        pred_valid_d   = 1'b0;
        prediction_d   = prediction_q;
        btb_hit_d      = btb_hit_q;
        predicted_pc_d = predicted_pc_q;
        pred_ghr_d     = pred_ghr_q;
        case (state_q)
            ST_INIT: begin
                if (init_idx_q == INIT_W'(INIT_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    init_idx_d = init_idx_q + INIT_W'(1);
                end
            end
            default: begin
                if (lookup_valid) begin
                    pred_valid_d   = 1'b1;
                    prediction_d   = lk_pred;
                    btb_hit_d      = lk_hit;
                    predicted_pc_d = lk_next_pc;
                    pred_ghr_d     = ghr_q;
                    ghr_d          = GHR_BITS'({ghr_q, lk_pred});
                end
                // Repair overrides the speculative shift of a same-cycle lookup.
                if (update_valid && mispred) begin
                    ghr_d = GHR_BITS'({update_ghr, update_taken});
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            init_idx_q     <= '0;
            ghr_q          <= '0;
            pred_valid_q   <= 1'b0;
            prediction_q   <= 1'b0;
            btb_hit_q      <= 1'b0;
            predicted_pc_q <= '0;
            pred_ghr_q     <= '0;
        end else begin
            state_q        <= state_d;
            init_idx_q     <= init_idx_d;
            ghr_q          <= ghr_d;
            pred_valid_q   <= pred_valid_d;
            prediction_q   <= prediction_d;
            btb_hit_q      <= btb_hit_d;
            predicted_pc_q <= predicted_pc_d;
            pred_ghr_q     <= pred_ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run) begin
                if (int'(init_idx_q) < PHT_DEPTH) begin
                    pht_q[PIDX_W'(init_idx_q)] <= CTR_WEAK_NT;
                end
                if (int'(init_idx_q) < BTB_DEPTH) begin
                    btb_valid_q[BIDX_W'(init_idx_q)] <= 1'b0;
                end
            end else if (update_valid) begin
                pht_q[up_pidx] <= sat_step(pht_q[up_pidx], update_taken);
                if (update_taken) begin
                    btb_valid_q[up_bidx] <= 1'b1;
                    btb_tag_q[up_bidx]   <= up_tag;
                    btb_tgt_q[up_bidx]   <= update_target;
                end
            end
        end
    end

    assign ready        = run;
    assign pred_valid   = pred_valid_q;
    assign prediction   = prediction_q;
    assign btb_hit      = btb_hit_q;
    assign predicted_pc = predicted_pc_q;
    assign pred_ghr     = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_gshare
//   Directed bench for branch_predictor_gshare with default parameters.
//   Expected values are worked out by hand from the table contents each step
//   leaves behind (PHT counters start at 1, GHR tracked alongside).
// ---------------------------------------------------------------------------
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] pc;
    logic        pred_valid;
    logic        prediction;
    logic        btb_hit;
    logic [31:0] predicted_pc;
    logic [5:0]  pred_ghr;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [5:0]  update_ghr;
    logic        mispred;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .lookup_valid (lookup_valid),
        .pc           (pc),
        .pred_valid   (pred_valid),
        .prediction   (prediction),
        .btb_hit      (btb_hit),
        .predicted_pc (predicted_pc),
        .pred_ghr     (pred_ghr),
        .update_valid (update_valid),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .update_target(update_target),
        .update_ghr   (update_ghr),
        .mispred      (mispred)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] a);
        lookup_valid = 1'b1;
        pc           = a;
        tick();
        lookup_valid = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] a, input logic tk, input logic [31:0] tgt,
                             input logic [5:0] g, input logic mp);
        update_valid  = 1'b1;
        update_pc     = a;
        update_taken  = tk;
        update_target = tgt;
        update_ghr    = g;
        mispred       = mp;
        tick();
        update_valid  = 1'b0;
        mispred       = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic p, input logic h,
                              input logic [31:0] npc, input logic [5:0] g);
        check({tag, "_valid"}, pred_valid, 1'b1);
        check({tag, "_pred"},  prediction, p);
        check({tag, "_hit"},   btb_hit, h);
        check({tag, "_npc"},   predicted_pc, npc);
        check({tag, "_ghr"},   pred_ghr, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int bad;
        int cnt;

        reset = 1'b1;
        lookup_valid = 1'b0; pc = '0;
        update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_target = '0; update_ghr = '0; mispred = 1'b0;
        tick();
        tick();
        check("rst_ready", ready, 1'b0);
        check("rst_pvalid", pred_valid, 1'b0);
        check("rst_pred", prediction, 1'b0);
        check("rst_hit", btb_hit, 1'b0);
        check("rst_npc", predicted_pc, 32'h0);
        check("rst_ghr", pred_ghr, 6'h0);

        // Init: lookups and updates must be ignored for 64 cycles.
        reset = 1'b0;
        lookup_valid = 1'b1; pc = 32'h100;
        update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
        update_target = 32'h55; update_ghr = '0; mispred = 1'b1;
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (ready !== 1'b0 || pred_valid !== 1'b0) bad++;
        end
        check("init_quiet", bad, 0);
        tick();
        lookup_valid = 1'b0; update_valid = 1'b0; mispred = 1'b0;
        check("init_ready", ready, 1'b1);
        check("init_pvalid", pred_valid, 1'b0);

        // 1. First lookup after init.
        do_lookup(32'h100);
        check_pred("first", 1'b0, 1'b0, 32'h104, 6'h0);
        tick();
        check("idle_pvalid", pred_valid, 1'b0);
        check("idle_hold", predicted_pc, 32'h104);

        // 2. Two taken updates on 0x200: counter 1->2->3.
        do_update(32'h200, 1'b1, 32'h80, 6'h0, 1'b0);
        do_update(32'h200, 1'b1, 32'h80, 6'h0, 1'b0);
        do_lookup(32'h200);
        check_pred("trained", 1'b1, 1'b1, 32'h80, 6'h0);
        // GHR = 1 now.

        // 3. Saturation. Mispredicted NT update also forces GHR back to 0.
        for (int i = 0; i < 5; i++) do_update(32'h200, 1'b1, 32'h80, 6'h0, 1'b0);
        do_update(32'h200, 1'b0, 32'h0, 6'h0, 1'b1);      // ctr 3->2, GHR=0
        do_lookup(32'h200);
        check_pred("sat_hi", 1'b1, 1'b1, 32'h80, 6'h0);   // GHR=1
        do_update(32'h200, 1'b0, 32'h0, 6'h0, 1'b0);      // ctr 1
        do_update(32'h200, 1'b0, 32'h0, 6'h0, 1'b1);      // ctr 0, GHR=0
        do_lookup(32'h200);
        check_pred("sat_lo", 1'b0, 1'b1, 32'h204, 6'h0);  // GHR stays 0
        do_update(32'h200, 1'b0, 32'h0, 6'h0, 1'b0);      // stays 0
        do_lookup(32'h200);
        check_pred("sat_floor", 1'b0, 1'b1, 32'h204, 6'h0);

        // 4. Speculative GHR: pc 0x310 base index 4; train entries 4,5,7.
        do_update(32'h310, 1'b1, 32'h1000, 6'h0, 1'b0);
        do_update(32'h310, 1'b1, 32'h1000, 6'h1, 1'b0);
        do_update(32'h310, 1'b1, 32'h1000, 6'h3, 1'b0);
        do_lookup(32'h310);
        check_pred("spec0", 1'b1, 1'b1, 32'h1000, 6'h00);
        do_lookup(32'h310);
        check_pred("spec1", 1'b1, 1'b1, 32'h1000, 6'h01);
        do_lookup(32'h310);
        check_pred("spec2", 1'b1, 1'b1, 32'h1000, 6'h03);
        // GHR = 0b000111; lookup indexes entry 4^7=3 (untrained) together with repair.
        lookup_valid  = 1'b1; pc = 32'h310;
        update_valid  = 1'b1; update_pc = 32'h310; update_taken = 1'b0;
        update_target = 32'h0; update_ghr = 6'b000011; mispred = 1'b1;
        tick();
        lookup_valid = 1'b0; update_valid = 1'b0; mispred = 1'b0;
        check_pred("repair_lk", 1'b0, 1'b1, 32'h314, 6'b000111);
        do_lookup(32'h100);
        check_pred("repaired", 1'b0, 1'b0, 32'h104, 6'b000110);
        // GHR = 12.

        // 5. BTB aliasing: 0x40 and 0x440 share BTB entry 0.
        do_update(32'h440, 1'b1, 32'h900, 6'h0, 1'b0);
        do_lookup(32'h40);
        check_pred("alias", 1'b0, 1'b0, 32'h44, 6'd12);
        do_lookup(32'h440);
        check_pred("alias_own", 1'b0, 1'b1, 32'h444, 6'd24);
        do_lookup(32'h200);
        check_pred("alias_evict", 1'b0, 1'b0, 32'h204, 6'd48);

        // 6. Reset mid-run, then re-init.
        reset = 1'b1;
        lookup_valid = 1'b1; pc = 32'h310;
        tick();
        reset = 1'b0;
        lookup_valid = 1'b0;
        check("rr_ready", ready, 1'b0);
        check("rr_pvalid", pred_valid, 1'b0);
        check("rr_pred", prediction, 1'b0);
        check("rr_hit", btb_hit, 1'b0);
        check("rr_npc", predicted_pc, 32'h0);
        check("rr_ghr", pred_ghr, 6'h0);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("rr_init_cycles", cnt, 64);
        do_lookup(32'h200);
        check_pred("rr_200", 1'b0, 1'b0, 32'h204, 6'h0);
        do_lookup(32'h310);
        check_pred("rr_310", 1'b0, 1'b0, 32'h314, 6'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
